ddio_out_burst_tx: RTL and testbench



---
 rtl/ddio_out_pkg.sv | 9 +
 rtl/ddio_out_fifo.sv | 43 ++++
 rtl/ddio_out_burst_tx.sv | 97 +++++++++
 tb/tb_ddio_out_burst_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddio_out_pkg.sv
// ddio_out_pkg: state encoding, counter widths and sizing helper for the DDR burst transmitter
package ddio_out_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, TURNOFF} state_t;
  localparam int TURN_W = 4;
  localparam int UCNT_W = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ddio_out_fifo.sv
// ddio_out_fifo: synchronous FIFO with count, full/empty and a registered ready flag
import ddio_out_pkg::*;
module ddio_out_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4
) (
  input  logic                      outclock,
  input  logic                      sclr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic                      ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEP = CW'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count_n;
  assign count_n = count + CW'(push) - CW'(pop);
  assign rdata = mem[rp];
  assign empty = count == '0;
  assign full = count == DEP;
  always_ff @(posedge outclock)
    if (push) mem[wp] <= wdata;
  // ready comes from the next count so it never depends combinationally on pop
  always_ff @(posedge outclock)
    if (sclr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ready <= 1'b1;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count_n;
      ready <= count_n < DEP;
    end
endmodule

// File: rtl/ddio_out_burst_tx.sv
// ddio_out_burst_tx: DDR burst transmitter with FIFO, oe/turnoff sequencing and underrun pulse.
// Define DDIO_OUT_UNDERRUN_COUNT_EN to add a saturating underrun_count output.
import ddio_out_pkg::*;
module ddio_out_burst_tx #(
  parameter int width = 1,
  parameter int DEPTH = 4,
  parameter int START_LEVEL = 2,
  parameter int TURNOFF_CYCLES = 2,
  parameter logic [width-1:0] IDLE_VALUE = '0
) (
  input  logic             outclock,
  input  logic             sclr,
  input  logic [width-1:0] din_h,
  input  logic [width-1:0] din_l,
  input  logic             din_last,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [width-1:0] dataout,
  output logic             oe,
  output logic             underrun,
  output logic             busy
`ifdef DDIO_OUT_UNDERRUN_COUNT_EN
  , output logic [UCNT_W-1:0] underrun_count
`endif
);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] START = CW'(START_LEVEL);
  typedef struct packed {
    logic last;
    logic [width-1:0] h;
    logic [width-1:0] l;
  } word_t;
  word_t wr_word, rd_word;
  state_t state, state_n;
  logic [TURN_W-1:0] tcnt, tcnt_n;
  logic [CW-1:0] count, last_cnt;
  logic empty, full, push, pop;
  logic [width-1:0] h_q, l_pre, l_q;
  assign wr_word = '{last: din_last, h: din_h, l: din_l};
  assign push = din_valid & din_ready & ~full;
  assign pop = (state == ACTIVE) & ~empty;
  assign busy = state != IDLE;
  assign oe = busy;
  assign dataout = outclock ? h_q : l_q;
  ddio_out_fifo #(.W(2 * width + 1), .DEPTH(DEPTH)) u_fifo (
    .outclock(outclock),
    .sclr(sclr),
    .push(push),
    .pop(pop),
    .wdata(wr_word),
    .rdata(rd_word),
    .count(count),
    .empty(empty),
    .full(full),
    .ready(din_ready)
  );
  always_comb begin
    state_n = state;
    tcnt_n = tcnt;
    case (state)
      IDLE: state_n = (count >= START || last_cnt != '0) ? ACTIVE : IDLE;
      ACTIVE:
        if (pop && rd_word.last) begin
          state_n = TURNOFF;
          tcnt_n = TURN_W'(TURNOFF_CYCLES);
        end
      TURNOFF:
        if (tcnt == '0) state_n = IDLE;
        else tcnt_n = tcnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // last_cnt tracks queued burst terminators so a short burst can start below START_LEVEL
  always_ff @(posedge outclock)
    if (sclr) begin
      state <= IDLE;
      tcnt <= '0;
      last_cnt <= '0;
      h_q <= IDLE_VALUE;
      l_pre <= IDLE_VALUE;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      last_cnt <= last_cnt + CW'(push & din_last) - CW'(pop & rd_word.last);
      h_q <= pop ? rd_word.h : IDLE_VALUE;
      l_pre <= pop ? rd_word.l : IDLE_VALUE;
      underrun <= (state == ACTIVE) & empty;
    end
  always_ff @(negedge outclock)
    l_q <= l_pre;
`ifdef DDIO_OUT_UNDERRUN_COUNT_EN
  always_ff @(posedge outclock)
    if (sclr) underrun_count <= '0;
    else if (underrun && underrun_count != '1) underrun_count <= underrun_count + 1'b1;
`endif
endmodule

// File: tb/tb_ddio_out_burst_tx.sv
// tb_ddio_out_burst_tx: directed checks of reset, burst, underrun, full FIFO and mid-burst reset
module tb_ddio_out_burst_tx;
  localparam logic [3:0] IV = 4'hA;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sclr[3], din_last[3], din_valid[3], din_ready[3], oe[3], underrun[3], busy[3];
  logic [3:0] din_h[3], din_l[3], dataout[3];
`ifdef DDIO_OUT_UNDERRUN_COUNT_EN
  logic [15:0] ucnt[3];
`endif
  int errors = 0, checks = 0;
  for (genvar g = 0; g < 3; g++) begin : gu
    ddio_out_burst_tx #(
      .width(4), .DEPTH(4), .START_LEVEL(g == 0 ? 2 : g == 1 ? 1 : 4),
      .TURNOFF_CYCLES(2), .IDLE_VALUE(IV)
    ) u (
      .outclock(clk), .sclr(sclr[g]), .din_h(din_h[g]), .din_l(din_l[g]),
      .din_last(din_last[g]), .din_valid(din_valid[g]), .din_ready(din_ready[g]),
      .dataout(dataout[g]), .oe(oe[g]), .underrun(underrun[g]), .busy(busy[g])
`ifdef DDIO_OUT_UNDERRUN_COUNT_EN
      , .underrun_count(ucnt[g])
`endif
    );
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic half();
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sclr[i] = 1'b1;
      din_valid[i] = 1'b1;
      din_h[i] = 4'h3;
      din_l[i] = 4'h4;
      din_last[i] = 1'b1;
    end
    repeat (3) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({din_ready[i], oe[i], busy[i], underrun[i], dataout[i]} !== {4'b1000, IV}) begin
          errors++;
          $display("FAIL reset_hi[%0d]: got rdy/oe/busy/ur/data=%b%b%b%b/%h want 1000/%h",
                   i, din_ready[i], oe[i], busy[i], underrun[i], dataout[i], IV);
        end
      end
      half();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dataout[i] !== IV) begin
          errors++;
          $display("FAIL reset_lo[%0d]: got %h want %h", i, dataout[i], IV);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      sclr[i] = 1'b0;
      din_valid[i] = 1'b0;
      din_last[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_nopush[%0d]: busy got %b want 0", i, busy[i]);
      end
    end
  endtask
  task automatic test_burst();
    logic [3:0] eh[6] = '{4'h1, 4'h3, 4'h5, IV, IV, IV};
    logic [3:0] el[6] = '{4'h2, 4'h4, 4'h6, IV, IV, IV};
    logic eoe[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] h, l;
    logic o;
    din_h[0] = 4'h1; din_l[0] = 4'h2; din_last[0] = 1'b0; din_valid[0] = 1'b1;
    tick();
    din_h[0] = 4'h3; din_l[0] = 4'h4;
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL burst_wait1: busy got %b want 0", busy[0]);
    end
    din_h[0] = 4'h5; din_l[0] = 4'h6; din_last[0] = 1'b1;
    tick();
    din_valid[0] = 1'b0; din_last[0] = 1'b0;
    checks++;
    if ({busy[0], oe[0], dataout[0]} !== {2'b11, IV}) begin
      errors++;
      $display("FAIL burst_start: busy/oe/data got %b%b/%h want 11/%h", busy[0], oe[0], dataout[0], IV);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      h = dataout[0]; o = oe[0];
      half();
      l = dataout[0];
      checks++;
      if ({o, h, l} !== {eoe[c], eh[c], el[c]}) begin
        errors++;
        $display("FAIL burst_cyc%0d: oe/h/l got %b/%h/%h want %b/%h/%h", c, o, h, l, eoe[c], eh[c], el[c]);
      end
    end
  endtask
  task automatic test_underrun();
    logic [3:0] eh[8] = '{IV, 4'h7, IV, IV, 4'h9, IV, IV, IV};
    logic [3:0] el[8] = '{IV, 4'h8, IV, IV, 4'h3, IV, IV, IV};
    logic eu[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic eoe[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] h, l;
    logic o, u;
    int pulses = 0;
    din_h[1] = 4'h7; din_l[1] = 4'h8; din_last[1] = 1'b0; din_valid[1] = 1'b1;
    tick();
    din_valid[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      h = dataout[1]; o = oe[1]; u = underrun[1];
      pulses += int'(u);
      half();
      l = dataout[1];
      checks++;
      if ({o, u, h, l} !== {eoe[c], eu[c], eh[c], el[c]}) begin
        errors++;
        $display("FAIL underrun_cyc%0d: oe/ur/h/l got %b/%b/%h/%h want %b/%b/%h/%h",
                 c, o, u, h, l, eoe[c], eu[c], eh[c], el[c]);
      end
      if (c == 2) begin
        din_h[1] = 4'h9; din_l[1] = 4'h3; din_last[1] = 1'b1; din_valid[1] = 1'b1;
      end
      if (c == 3) begin
        din_valid[1] = 1'b0; din_last[1] = 1'b0;
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL underrun_pulses: got %0d want 2", pulses);
    end
  endtask
  task automatic test_full();
    logic [3:0] rh[6], rl[6], h, l;
    logic will, o_pre, ready_at4, oe_at5;
    int sent = 0, n = 0;
    ready_at4 = 1'bx;
    oe_at5 = 1'bx;
    for (int c = 0; c < 16; c++) begin
      din_valid[2] = sent < 6;
      din_h[2] = 4'(sent + 1);
      din_l[2] = 4'(sent);
      din_last[2] = sent == 5;
      will = din_valid[2] & din_ready[2];
      o_pre = oe[2];
      tick();
      if (will) begin
        sent++;
        if (sent == 4) ready_at4 = din_ready[2];
        if (sent == 5) oe_at5 = o_pre;
      end
      h = dataout[2];
      half();
      l = dataout[2];
      if (h !== IV) begin
        if (n < 6) begin
          rh[n] = h;
          rl[n] = l;
        end
        n++;
      end
    end
    din_valid[2] = 1'b0;
    din_last[2] = 1'b0;
    checks++;
    if (ready_at4 !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_drop: din_ready after 4 pushes got %b want 0", ready_at4);
    end
    checks++;
    if (oe_at5 !== 1'b1) begin
      errors++;
      $display("FAIL full_5th_push: oe before 5th push got %b want 1", oe_at5);
    end
    checks++;
    if (sent != 6 || n != 6) begin
      errors++;
      $display("FAIL full_counts: accepted/sent-out got %0d/%0d want 6/6", sent, n);
    end
    for (int k = 0; k < 6 && k < n; k++) begin
      checks++;
      if ({rh[k], rl[k]} !== {4'(k + 1), 4'(k)}) begin
        errors++;
        $display("FAIL full_order%0d: got %h/%h want %h/%h", k, rh[k], rl[k], 4'(k + 1), 4'(k));
      end
    end
  endtask
  task automatic test_mid_reset();
    din_last[0] = 1'b0; din_valid[0] = 1'b1;
    din_h[0] = 4'h1; din_l[0] = 4'h2;
    tick();
    din_h[0] = 4'h3; din_l[0] = 4'h4;
    tick();
    din_h[0] = 4'h5; din_l[0] = 4'h6;
    tick();
    din_valid[0] = 1'b0;
    tick();
    checks++;
    if ({oe[0], dataout[0]} !== {1'b1, 4'h1}) begin
      errors++;
      $display("FAIL midrst_pre: oe/data got %b/%h want 1/1", oe[0], dataout[0]);
    end
    sclr[0] = 1'b1;
    din_valid[0] = 1'b1;
    tick();
    checks++;
    if ({oe[0], busy[0], dataout[0]} !== {2'b00, IV}) begin
      errors++;
      $display("FAIL midrst_hi: oe/busy/data got %b%b/%h want 00/%h", oe[0], busy[0], dataout[0], IV);
    end
    half();
    checks++;
    if (dataout[0] !== IV) begin
      errors++;
      $display("FAIL midrst_lo: got %h want %h", dataout[0], IV);
    end
    sclr[0] = 1'b0;
    din_valid[0] = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy[0], din_ready[0], dataout[0]} !== {2'b01, IV}) begin
      errors++;
      $display("FAIL midrst_empty: busy/rdy/data got %b%b/%h want 01/%h", busy[0], din_ready[0], dataout[0], IV);
    end
  endtask
`ifdef DDIO_OUT_UNDERRUN_COUNT_EN
  task automatic test_ucount();
    sclr[1] = 1'b1;
    tick();
    sclr[1] = 1'b0;
    checks++;
    if (ucnt[1] !== 16'd0) begin
      errors++;
      $display("FAIL ucount_clear0: got %0d want 0", ucnt[1]);
    end
    din_h[1] = 4'h7; din_l[1] = 4'h8; din_last[1] = 1'b0; din_valid[1] = 1'b1;
    tick();
    din_valid[1] = 1'b0;
    repeat (4) tick();
    din_h[1] = 4'h9; din_l[1] = 4'h3; din_last[1] = 1'b1; din_valid[1] = 1'b1;
    tick();
    din_valid[1] = 1'b0; din_last[1] = 1'b0;
    repeat (5) tick();
    checks++;
    if (ucnt[1] !== 16'd3) begin
      errors++;
      $display("FAIL ucount_three: got %0d want 3", ucnt[1]);
    end
    sclr[1] = 1'b1;
    tick();
    sclr[1] = 1'b0;
    checks++;
    if (ucnt[1] !== 16'd0) begin
      errors++;
      $display("FAIL ucount_clear: got %0d want 0", ucnt[1]);
    end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_burst();
    test_underrun();
    test_full();
    test_mid_reset();
`ifdef DDIO_OUT_UNDERRUN_COUNT_EN
    test_ucount();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
